// File: rtl/frame_buf_pkg.sv
// Shared types and constants for the ping-pong frame buffer controller.
package frame_buf_pkg;

  typedef enum logic {
    W_FILL = 1'b0,
    W_WAIT = 1'b1
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_SCAN = 1'b1
  } rd_state_t;

  localparam logic BANK0 = 1'b0;
  localparam logic BANK1 = 1'b1;

  localparam int DROP_CNT_W = 8;

endpackage

// File: rtl/frame_buf_if.sv
// Pixel stream, display and data_mem signals of the frame buffer controller.
interface frame_buf_if
  import frame_buf_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
);

  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic                  out_req;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_sof;
  logic                  mem_wr_en;
  logic [ADDR_WIDTH:0]   mem_wr_addr;
  logic [DATA_WIDTH-1:0] mem_wr_data;
  logic                  mem_rd_en;
  logic [ADDR_WIDTH:0]   mem_rd_addr;
  logic [DATA_WIDTH-1:0] mem_rd_data;
  logic [DROP_CNT_W-1:0] drop_cnt;

  modport slave (
    input  in_valid, in_data, out_req, mem_rd_data,
    output in_ready, out_valid, out_data, out_sof,
           mem_wr_en, mem_wr_addr, mem_wr_data, mem_rd_en, mem_rd_addr, drop_cnt
  );

  modport master (
    output in_valid, in_data, out_req, mem_rd_data,
    input  in_ready, out_valid, out_data, out_sof,
           mem_wr_en, mem_wr_addr, mem_wr_data, mem_rd_en, mem_rd_addr, drop_cnt
  );

endinterface

// File: rtl/frame_buf_addr_cnt.sv
// Per-bank pixel address counter; wraps to zero after the last pixel of a frame.
module frame_buf_addr_cnt #(
  parameter int ADDR_WIDTH   = 3,
  parameter int FRAME_PIXELS = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  inc,
  input  logic                  clr,
  output logic [ADDR_WIDTH-1:0] cnt,
  output logic                  last
);

  localparam logic [ADDR_WIDTH-1:0] LAST_CNT = ADDR_WIDTH'(FRAME_PIXELS - 1);

  assign last = (cnt == LAST_CNT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr || (inc && last)) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/frame_buf_ctrl.sv
// Ping-pong frame buffer controller over a dual-port data_mem (bank = address MSB).
// Define FRAME_BUF_DROP_EN to drop frames instead of back-pressuring the writer.
module frame_buf_ctrl
  import frame_buf_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 3,
  parameter int FRAME_PIXELS = 8
) (
  input logic        clk,
  input logic        reset,
  frame_buf_if.slave bus
);

  wr_state_t             wr_state;
  rd_state_t             rd_state;
  logic                  wr_bank, rd_bank, sof_pend;
  logic [ADDR_WIDTH-1:0] wr_cnt, rd_cnt;
  logic                  wr_last, rd_last;
  logic                  wr_accept, rd_accept, wr_done, swap;
  logic [DATA_WIDTH-1:0] data_hold;

  assign wr_accept = bus.in_valid & bus.in_ready;
  assign rd_accept = (rd_state == R_SCAN) & bus.out_req;
  assign wr_done   = wr_accept & wr_last;

`ifdef FRAME_BUF_DROP_EN
  logic                  drop;
  logic [DROP_CNT_W-1:0] drop_q;

  assign bus.in_ready = 1'b1;
  // Completion swaps immediately when the reader is free, else the frame is overwritten.
  assign swap         = wr_done & (rd_state == R_IDLE);
  assign drop         = wr_done & (rd_state != R_IDLE);
  assign bus.drop_cnt = drop_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_q <= '0;
    end else if (drop && (drop_q != {DROP_CNT_W{1'b1}})) begin
      drop_q <= drop_q + 1'b1;
    end
  end
`else
  assign bus.in_ready = (wr_state == W_FILL);
  assign swap         = (wr_state == W_WAIT) & (rd_state == R_IDLE);
  assign bus.drop_cnt = '0;
`endif

  assign bus.mem_wr_en   = wr_accept;
  assign bus.mem_wr_addr = {wr_bank, wr_cnt};
  assign bus.mem_wr_data = bus.in_data;
  assign bus.mem_rd_en   = rd_accept;
  assign bus.mem_rd_addr = {rd_bank, rd_cnt};
  assign bus.out_data    = bus.out_valid ? bus.mem_rd_data : data_hold;

  frame_buf_addr_cnt #(.ADDR_WIDTH(ADDR_WIDTH), .FRAME_PIXELS(FRAME_PIXELS)) u_wr_cnt (
    .clk(clk), .reset(reset), .inc(wr_accept), .clr(swap), .cnt(wr_cnt), .last(wr_last)
  );

  frame_buf_addr_cnt #(.ADDR_WIDTH(ADDR_WIDTH), .FRAME_PIXELS(FRAME_PIXELS)) u_rd_cnt (
    .clk(clk), .reset(reset), .inc(rd_accept), .clr(swap), .cnt(rd_cnt), .last(rd_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_state      <= W_FILL;
      rd_state      <= R_IDLE;
      wr_bank       <= BANK0;
      rd_bank       <= BANK1;
      sof_pend      <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_sof   <= 1'b0;
      data_hold     <= '0;
    end else begin
      bus.out_valid <= rd_accept;
      bus.out_sof   <= rd_accept & sof_pend;
      if (bus.out_valid) begin
        data_hold <= bus.mem_rd_data;
      end
      if (swap) begin
        rd_bank  <= wr_bank;
        wr_bank  <= ~wr_bank;
        wr_state <= W_FILL;
        rd_state <= R_SCAN;
        sof_pend <= 1'b1;
      end else begin
`ifndef FRAME_BUF_DROP_EN
        if (wr_done) begin
          wr_state <= W_WAIT;
        end
`endif
        if (rd_accept) begin
          sof_pend <= 1'b0;
          if (rd_last) begin
            rd_state <= R_IDLE;
          end
        end
      end
    end
  end

endmodule
